// File: rtl/lcd_class_overlay.sv
// Pixel source for the LCD RGB top: forwards frame-buffer FIFO pixels and overlays a
// class banner (palette box, white border, tick blocks) that only changes at frame start.
module lcd_class_overlay #(
  parameter int unsigned BANNER_X0   = 16,
  parameter int unsigned BANNER_Y0   = 16,
  parameter int unsigned BANNER_W    = 192,
  parameter int unsigned BANNER_H    = 32,
  parameter int unsigned HOLD_FRAMES = 30
) (
  input  logic        lcd_clk,
  input  logic        sys_rst,
  input  logic        out_vsync,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic        data_req,
  input  logic [3:0]  obj_class,
  input  logic        class_valid,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_data,
  output logic [15:0] pixel_out,
  output logic        banner_on
);

  localparam int unsigned CW      = 4;
  localparam int unsigned PW      = 16;
  localparam int unsigned HW      = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int unsigned NTICK   = 15;
  localparam logic [CW-1:0] NO_CLASS = 4'hF;
  localparam logic [PW-1:0] WHITE    = 16'hFFFF;

  localparam logic signed [11:0] X0_S = 12'(BANNER_X0);
  localparam logic signed [11:0] Y0_S = 12'(BANNER_Y0);
  localparam logic signed [11:0] W_S  = 12'(BANNER_W);
  localparam logic signed [11:0] H_S  = 12'(BANNER_H);

  typedef enum logic {NO_OBJ, SHOW} state_t;

  state_t          state_q, state_d;
  logic            vsync_q;
  logic            pend_valid_q, pend_valid_d;
  logic [CW-1:0]   pend_class_q, pend_class_d;
  logic [CW-1:0]   shown_class_q, shown_class_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            ovl_q;
  logic [PW-1:0]   col_q;
  logic            banner_on_q;

  logic            frame_start_c;
  logic            eff_valid_c;
  logic [CW-1:0]   eff_class_c;
  logic signed [11:0] xr_c, yr_c;
  logic            inside_c, border_c, tick_row_c, tick_c, hit_c;
  logic [PW-1:0]   col_c;

  function automatic logic [PW-1:0] palette(input logic [CW-1:0] c);
    case (c)
      4'd0:    return 16'hF800;
      4'd1:    return 16'h07E0;
      4'd2:    return 16'h001F;
      4'd3:    return 16'hFFE0;
      4'd4:    return 16'hF81F;
      4'd5:    return 16'h07FF;
      4'd6:    return 16'hFD20;
      4'd7:    return 16'h8010;
      4'd8:    return 16'h0410;
      4'd9:    return 16'h8400;
      4'd10:   return 16'h041F;
      4'd11:   return 16'hF8B2;
      4'd12:   return 16'hBFE0;
      4'd13:   return 16'h7BEF;
      4'd14:   return 16'hA145;
      default: return 16'h0000;
    endcase
  endfunction

  assign frame_start_c = out_vsync & ~vsync_q;
  assign fifo_rd_en    = data_req;
  assign pixel_out     = ovl_q ? col_q : fifo_data;
  assign banner_on     = banner_on_q;

  // Signed relative coordinates so pixels left of / above the banner never wrap inside
  assign xr_c       = $signed({1'b0, pixel_xpos}) - X0_S;
  assign yr_c       = $signed({1'b0, pixel_ypos}) - Y0_S;
  assign inside_c   = (xr_c >= 12'sd0) && (xr_c < W_S) && (yr_c >= 12'sd0) && (yr_c < H_S);
  assign border_c   = (xr_c < 12'sd2) || (yr_c < 12'sd2) ||
                      (xr_c >= W_S - 12'sd2) || (yr_c >= H_S - 12'sd2);
  assign tick_row_c = (yr_c >= 12'sd4) && (yr_c <= H_S - 12'sd5);

  always_comb begin
    tick_c = 1'b0;
    for (int i = 0; i < int'(NTICK); i++) begin
      if ((CW'(i) <= shown_class_q) &&
          (xr_c >= $signed(12'(4 + 12 * i))) && (xr_c <= $signed(12'(11 + 12 * i))))
        tick_c = 1'b1;
    end
    tick_c = tick_c & tick_row_c;
    col_c  = (border_c || tick_c) ? WHITE : palette(shown_class_q);
    hit_c  = inside_c && (state_q == SHOW);
  end

  // Class bookkeeping; a strobe coincident with frame start is applied to that frame
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_class_d  = pend_class_q;
    shown_class_d = shown_class_q;
    hold_cnt_d    = hold_cnt_q;
    eff_valid_c   = pend_valid_q | class_valid;
    eff_class_c   = class_valid ? obj_class : pend_class_q;

    if (class_valid) begin
      pend_valid_d = 1'b1;
      pend_class_d = obj_class;
    end

    if (frame_start_c) begin
      pend_valid_d = 1'b0;
      if (eff_valid_c) begin
        if (eff_class_c != NO_CLASS) begin
          shown_class_d = eff_class_c;
          hold_cnt_d    = HW'(HOLD_FRAMES - 1);
          state_d       = SHOW;
        end else begin
          state_d = NO_OBJ;
        end
      end else if (state_q == SHOW) begin
        if (hold_cnt_q == '0) state_d = NO_OBJ;
        else                  hold_cnt_d = hold_cnt_q - HW'(1);
      end
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      state_q       <= NO_OBJ;
      vsync_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_class_q  <= NO_CLASS;
      shown_class_q <= NO_CLASS;
      hold_cnt_q    <= '0;
      ovl_q         <= 1'b0;
      col_q         <= '0;
      banner_on_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= out_vsync;
      pend_valid_q  <= pend_valid_d;
      pend_class_q  <= pend_class_d;
      shown_class_q <= shown_class_d;
      hold_cnt_q    <= hold_cnt_d;
      ovl_q         <= data_req & hit_c;
      col_q         <= col_c;
      banner_on_q   <= (state_d == SHOW);
    end
  end

endmodule

// File: tb/tb_lcd_class_overlay.sv
// Directed bench for lcd_class_overlay: FIFO ramp model, banner model and pixel scoreboard.
module tb_lcd_class_overlay;

  localparam int X0   = 16;
  localparam int Y0   = 16;
  localparam int W    = 192;
  localparam int H    = 32;
  localparam int HOLD = 3;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        out_vsync = 1'b0;
  logic [10:0] pixel_xpos = '0;
  logic [10:0] pixel_ypos = '0;
  logic        data_req = 1'b0;
  logic [3:0]  obj_class = 4'hF;
  logic        class_valid = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] fifo_data = 16'h0000;
  logic [15:0] pixel_out;
  logic        banner_on;

  logic [15:0] ramp = 16'h0000;
  logic [15:0] exp_ramp = 16'h0000;
  logic [15:0] sb[$];
  int          n_assert = 0;
  int          n_fail = 0;

  logic [15:0] pal [0:14] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFE0, 16'hF81F,
                              16'h07FF, 16'hFD20, 16'h8010, 16'h0410, 16'h8400,
                              16'h041F, 16'hF8B2, 16'hBFE0, 16'h7BEF, 16'hA145};

  bit   m_show = 1'b0;
  int   m_cls = 0;
  int   m_hold = 0;
  bit   m_pv = 1'b0;
  int   m_pc = 15;

  lcd_class_overlay #(
    .BANNER_X0(X0), .BANNER_Y0(Y0), .BANNER_W(W), .BANNER_H(H), .HOLD_FRAMES(HOLD)
  ) dut (
    .lcd_clk     (clk),
    .sys_rst     (sys_rst),
    .out_vsync   (out_vsync),
    .pixel_xpos  (pixel_xpos),
    .pixel_ypos  (pixel_ypos),
    .data_req    (data_req),
    .obj_class   (obj_class),
    .class_valid (class_valid),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .pixel_out   (pixel_out),
    .banner_on   (banner_on)
  );

  always #5 clk = ~clk;

  // Read FIFO: next ramp word appears one cycle after each read enable
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data <= ramp;
      ramp      <= ramp + 16'd1;
    end
  end

  function automatic logic [15:0] model_pix(input int x, input int y, input logic [15:0] rv);
    int xr, yr;
    xr = x - X0;
    yr = y - Y0;
    if (!m_show || xr < 0 || xr >= W || yr < 0 || yr >= H) return rv;
    if (xr < 2 || yr < 2 || xr >= W - 2 || yr >= H - 2) return 16'hFFFF;
    if (yr >= 4 && yr <= H - 5 && xr >= 4 && ((xr - 4) % 12) < 8 && ((xr - 4) / 12) <= m_cls)
      return 16'hFFFF;
    return pal[m_cls];
  endfunction

  task automatic cyc();
    logic        r;
    logic [15:0] e;
    r = data_req;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      n_assert++;
      if (sb.size() == 0) begin
        n_fail++;
        $error("FAIL pixel_out scoreboard empty got %h", pixel_out);
      end else begin
        e = sb.pop_front();
        assert (pixel_out === e) else begin
          n_fail++;
          $error("FAIL pixel_out x=%0d y=%0d got %h exp %h", pixel_xpos, pixel_ypos, pixel_out, e);
        end
      end
    end
  endtask

  task automatic req(input int x, input int y);
    data_req   = 1'b1;
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    sb.push_back(model_pix(x, y, exp_ramp));
    exp_ramp = exp_ramp + 16'd1;
    #1;
    n_assert++;
    assert (fifo_rd_en === 1'b1) else begin
      n_fail++;
      $error("FAIL fifo_rd_en got %b exp 1", fifo_rd_en);
    end
    cyc();
    data_req = 1'b0;
  endtask

  task automatic chk_banner(input string tag);
    n_assert++;
    assert (banner_on === m_show) else begin
      n_fail++;
      $error("FAIL banner_on %s got %b exp %b", tag, banner_on, m_show);
    end
  endtask

  task automatic strobe(input int c);
    class_valid = 1'b1;
    obj_class   = 4'(c);
    m_pv = 1'b1;
    m_pc = c;
    cyc();
    class_valid = 1'b0;
  endtask

  task automatic frame(input bit with_cls, input int c);
    out_vsync = 1'b1;
    if (with_cls) begin
      class_valid = 1'b1;
      obj_class   = 4'(c);
      m_pv = 1'b1;
      m_pc = c;
    end
    cyc();
    class_valid = 1'b0;
    out_vsync   = 1'b0;
    if (m_pv) begin
      if (m_pc != 15) begin
        m_show = 1'b1;
        m_cls  = m_pc;
        m_hold = HOLD - 1;
      end else begin
        m_show = 1'b0;
      end
    end else if (m_show) begin
      if (m_hold == 0) m_show = 1'b0;
      else             m_hold--;
    end
    m_pv = 1'b0;
    cyc();
  endtask

  initial begin
    @(negedge clk);
    cyc();
    cyc();
    n_assert++;
    assert (banner_on === 1'b0) else begin
      n_fail++;
      $error("FAIL reset banner_on got %b exp 0", banner_on);
    end
    n_assert++;
    assert (pixel_out === 16'h0000) else begin
      n_fail++;
      $error("FAIL reset pixel_out got %h exp 0000", pixel_out);
    end
    n_assert++;
    assert (fifo_rd_en === 1'b0) else begin
      n_fail++;
      $error("FAIL reset fifo_rd_en got %b exp 0", fifo_rd_en);
    end
    sys_rst = 1'b0;
    cyc();

    // Plain ramp passthrough, no banner
    for (int i = 0; i < 8; i++) req(100 + i, 100);
    cyc();
    chk_banner("idle");

    // Mid-frame class capture leaves the current frame untouched
    strobe(2);
    req(20, 20);
    req(40, 30);
    chk_banner("pending");

    frame(1'b0, 0);
    chk_banner("frame1");
    req(16, 16);
    req(20, 20);
    req(26, 24);
    req(30, 24);
    req(36, 24);
    req(48, 24);
    req(60, 24);
    req(5, 20);
    req(X0 + W - 1, 20);
    req(X0 + W, 20);
    req(20, Y0 + H - 3);
    req(20, Y0 + H - 2);
    req(20, Y0 + H);

    frame(1'b0, 0);
    chk_banner("frame2");
    req(60, 24);
    frame(1'b0, 0);
    chk_banner("frame3");
    req(60, 24);
    frame(1'b0, 0);
    chk_banner("frame4");
    req(60, 24);
    req(16, 16);

    // Strobe coincident with frame start applies to that frame
    frame(1'b1, 5);
    chk_banner("coincident");
    req(40, 30);
    req(24, 24);
    req(5, 24);

    strobe(15);
    req(40, 30);
    frame(1'b0, 0);
    chk_banner("noobj");
    req(40, 30);

    strobe(3);
    frame(1'b0, 0);
    chk_banner("class3");
    req(40, 30);
    req(44, 24);

    // Reset in the middle of a banner row
    sys_rst  = 1'b1;
    m_show   = 1'b0;
    m_pv     = 1'b0;
    m_hold   = 0;
    req(45, 24);
    sys_rst  = 1'b0;
    chk_banner("reset");
    req(46, 24);
    frame(1'b0, 0);
    chk_banner("after_reset");
    req(46, 24);

    strobe(14);
    frame(1'b0, 0);
    chk_banner("class14");
    req(X0 + 4 + 12 * 14, 24);
    req(X0 + 12 + 12 * 14, 24);
    req(X0 + 188, 24);

    cyc();
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard leftover got %0d exp 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
